// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared definitions for the FIR front-end stages: sample width
//               and tap-count defaults, feeder FSM state encoding and a small
//               counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

  // Defaults shared by the feeder and the serial FIR it drives
  localparam int DATA_SIZE_DEFAULT = 9;
  localparam int N_TAPS_DEFAULT    = 3;

  // Feeder FSM state encoding (explicit 2-bit width)
  typedef logic [1:0] fir_state_t;
  localparam fir_state_t c_st_idle  = 2'd0;
  localparam fir_state_t c_st_issue = 2'd1;
  localparam fir_state_t c_st_gap   = 2'd2;

  // Bits needed to hold any value in 0..max_val (never less than one bit)
  function automatic int fir_cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage : fir_pkg
`default_nettype wire

// File: rtl/fir_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fir_sync_fifo
// Description : Single-clock FIFO built from flops. Pointers wrap modulo
//               DEPTH (a power of two); full/empty are decoded from the
//               occupancy count, never from pointer equality. Head is
//               presented combinationally on dout.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_lw = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [c_aw-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_aw-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_lw-1:0]  level_q,  level_d;

  logic w_do_push;
  logic w_do_pop;

  // Status decoded from the registered count only
  assign full      = (level_q == c_lw'(DEPTH));
  assign empty     = (level_q == '0);
  assign level     = level_q;
  assign dout      = mem_q[rd_ptr_q];

  // Overflow/underflow requests are dropped rather than corrupting state
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Storage write: only the slot under the write pointer changes
  always_comb begin
    mem_d = mem_q;
    if (w_do_push) begin
      mem_d[wr_ptr_q] = din;
    end
  end

  // Pointer advance and occupancy bookkeeping; push+pop leaves level unchanged
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (w_do_push) begin
      wr_ptr_d = wr_ptr_q + c_aw'(1);
    end
    if (w_do_pop) begin
      rd_ptr_d = rd_ptr_q + c_aw'(1);
    end
    case ({w_do_push, w_do_pop})
      2'b10:   level_d = level_q + c_lw'(1);
      2'b01:   level_d = level_q - c_lw'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage array needs no reset: occupancy decides what is valid
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule : fir_sync_fifo
`default_nettype wire

// File: rtl/fir_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module      : fir_sample_feeder
// Description : Buffers signed samples in a small FIFO and releases them to a
//               serial FIR as one-cycle data_ready strobes spaced exactly
//               MIN_GAP cycles apart while samples are available.
//               Optional build macro FIR_FEEDER_STATS_EN adds a 16-bit
//               wrapping issued_cnt output counting strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_sample_feeder
  import fir_pkg::*;
#(
  parameter int DATA_SIZE  = DATA_SIZE_DEFAULT,
  parameter int N_TAPS     = N_TAPS_DEFAULT,
  parameter int MIN_GAP    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [DATA_SIZE-1:0]   in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic signed [DATA_SIZE-1:0]   data,
  output logic                          data_ready,
`ifdef FIR_FEEDER_STATS_EN
  output logic [15:0]                   issued_cnt,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  // The serial FIR needs N_TAPS cycles per sample, so never space strobes
  // closer than that even if MIN_GAP is configured below the legal range.
  localparam int c_eff_gap  = (MIN_GAP >= N_TAPS) ? MIN_GAP : N_TAPS;
  localparam int c_gw       = fir_cnt_width(c_eff_gap);
  localparam int c_gap_load = (c_eff_gap >= 2) ? (c_eff_gap - 2) : 0;
  // Gap of one: ISSUE behaves like IDLE so back-to-back strobes are possible
  localparam bit c_single   = (c_eff_gap == 1);
  // Gap of two: ISSUE alone provides the spacing, GAP is skipped
  localparam bit c_no_gap   = (c_eff_gap == 2);

  fir_state_t             state_q, state_d;
  logic [DATA_SIZE-1:0]   data_q, data_d;
  logic                   data_ready_q, data_ready_d;
  logic [c_gw-1:0]        gap_cnt_q, gap_cnt_d;

  logic                   w_push;
  logic                   w_pop;
  logic [DATA_SIZE-1:0]   w_head;
  logic                   w_full;
  logic                   w_empty;

  // in_ready comes straight from the FIFO's registered count; reset
  // blocks any push so in_valid is ignored while rst is high.
  assign in_ready   = ~w_full;
  assign w_push     = in_valid & ~w_full & ~rst;
  assign data       = data_q;
  assign data_ready = data_ready_q;

  fir_sync_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (in_data),
    .pop   (w_pop),
    .dout  (w_head),
    .level (level),
    .full  (w_full),
    .empty (w_empty)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: IDLE issues when data waits, ISSUE/GAP time the spacing
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle: begin
        if (!w_empty) begin
          state_d = c_st_issue;
        end
      end
      c_st_issue: begin
        if (c_single) begin
          state_d = w_empty ? c_st_idle : c_st_issue;
        end else if (c_no_gap) begin
          state_d = c_st_idle;
        end else begin
          state_d = c_st_gap;
        end
      end
      c_st_gap: begin
        // Leave as the counter decrements to zero so IDLE pops on time
        if (gap_cnt_q <= c_gw'(1)) begin
          state_d = c_st_idle;
        end
      end
      default: state_d = c_st_idle;
    endcase
  end

  // FSM outputs: pop decision, data capture, strobe and gap counter
  always_comb begin
    w_pop        = 1'b0;
    data_d       = data_q;
    data_ready_d = 1'b0;
    gap_cnt_d    = gap_cnt_q;
    case (state_q)
      c_st_idle: begin
        w_pop = ~w_empty;
      end
      c_st_issue: begin
        if (c_single) begin
          w_pop = ~w_empty;
        end else begin
          gap_cnt_d = c_gw'(c_gap_load);
        end
      end
      c_st_gap: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - c_gw'(1);
        end
      end
      default: begin
        w_pop = 1'b0;
      end
    endcase
    if (w_pop) begin
      data_d       = w_head;
      data_ready_d = 1'b1;
    end
  end

  // Output and counter registers; data holds its value between strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q       <= '0;
      data_ready_q <= 1'b0;
      gap_cnt_q    <= '0;
    end else begin
      data_q       <= data_d;
      data_ready_q <= data_ready_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

`ifdef FIR_FEEDER_STATS_EN
  logic [15:0] issued_cnt_q, issued_cnt_d;

  assign issued_cnt = issued_cnt_q;

  // Count strobes; wraps naturally at 16 bits
  always_comb begin
    issued_cnt_d = issued_cnt_q + {15'd0, w_pop};
  end

  // Strobe counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      issued_cnt_q <= '0;
    end else begin
      issued_cnt_q <= issued_cnt_d;
    end
  end
`endif

endmodule : fir_sample_feeder
`default_nettype wire

// File: tb/tb_fir_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_sample_feeder
// Description : Directed self-checking bench for fir_sample_feeder with the
//               default configuration (DATA_SIZE=9, MIN_GAP=3, FIFO_DEPTH=4).
//               Build with FIR_FEEDER_STATS_EN to include the counter checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_sample_feeder;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [8:0]        in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [8:0] data;
  logic              data_ready;
  logic [2:0]        level;
`ifdef FIR_FEEDER_STATS_EN
  logic [15:0]       issued_cnt;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int strb_val[$];
  int strb_cyc[$];

  fir_sample_feeder #(
    .DATA_SIZE  (9),
    .N_TAPS     (3),
    .MIN_GAP    (3),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data       (data),
    .data_ready (data_ready),
`ifdef FIR_FEEDER_STATS_EN
    .issued_cnt (issued_cnt),
`endif
    .level      (level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe recorder, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst && data_ready === 1'b1) begin
      strb_val.push_back(int'(data));
      strb_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int q_at(input int i);
    return (i < strb_val.size()) ? strb_val[i] : 32'sh7fff_ffff;
  endfunction

  function automatic int c_at(input int i);
    return (i < strb_cyc.size()) ? strb_cyc[i] : 0;
  endfunction

  task automatic clear_strobes();
    strb_val.delete();
    strb_cyc.delete();
  endtask

  initial begin
    int v;
    int n_acc;
    int budget;
    int min_sp;
    bit acc;
    bit full_seen;

    // ---------------- reset, with in_valid asserted during reset ----------
    in_valid = 1'b1;
    in_data  = 9'd77;
    tick(3);
    check("rst_data", data, 0);
    check("rst_rdy", data_ready, 0);
    check("rst_level", level, 0);
    check("rst_in_ready", in_ready, 1);
    in_valid = 1'b0;
    rst      = 1'b0;
    tick(2);
    check("rst_ignored_valid", level, 0);
    check("rst_no_strobe", data_ready, 0);

    // ---------------- single sample -----------------------------------------
    in_valid = 1'b1;
    in_data  = 9'sd5;
    tick(1);
    in_valid = 1'b0;
    check("single_level_push", level, 1);
    check("single_rdy_early", data_ready, 0);
    tick(1);
    check("single_rdy", data_ready, 1);
    check("single_data", data, 5);
    check("single_level_pop", level, 0);
    tick(1);
    check("single_rdy_drop", data_ready, 0);
    check("single_hold", data, 5);
    tick(5);

    // ---------------- burst -3, 7, 100 -------------------------------------
    clear_strobes();
    in_valid = 1'b1;
    in_data  = -9'sd3;
    tick(1);
    in_data  = 9'sd7;
    tick(1);
    check("burst_push_pop_level", level, 1);
    in_data  = 9'sd100;
    tick(1);
    in_valid = 1'b0;
    check("burst_level", level, 2);
    tick(12);
    check("burst_count", strb_val.size(), 3);
    check("burst_v0", q_at(0), -3);
    check("burst_v1", q_at(1), 7);
    check("burst_v2", q_at(2), 100);
    check("burst_gap01", c_at(1) - c_at(0), 3);
    check("burst_gap12", c_at(2) - c_at(1), 3);
    check("burst_hold", data, 100);

    // ---------------- full: in_valid held 8 cycles -------------------------
    clear_strobes();
    v = 11;
    n_acc = 0;
    full_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = v[8:0];
      acc      = in_ready;
      tick(1);
      if (acc) begin
        v++;
        n_acc++;
      end
      if (level == 3'd4) begin
        full_seen = 1'b1;
        check("full_in_ready", in_ready, 0);
      end
    end
    in_valid = 1'b0;
    check("full_seen", full_seen, 1);
    check("full_accepted", n_acc, 6);
    check("full_release_level", level, 3);
    check("full_release_ready", in_ready, 1);
    tick(25);
    check("full_count", strb_val.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("full_v%0d", i), q_at(i), 11 + i);
    end

    // ---------------- reset mid-GAP -----------------------------------------
    in_valid = 1'b1;
    in_data  = 9'd21;
    tick(1);
    in_data  = 9'd22;
    tick(1);
    in_data  = 9'd23;
    tick(1);
    in_valid = 1'b0;
    check("midgap_level", level, 2);
    rst = 1'b1;
    tick(1);
    clear_strobes();
    check("midgap_rst_data", data, 0);
    check("midgap_rst_level", level, 0);
    check("midgap_rst_rdy", data_ready, 0);
    rst = 1'b0;
    tick(1);
    check("midgap_in_ready", in_ready, 1);
    tick(5);
    check("midgap_no_strobe", strb_val.size(), 0);
    check("midgap_data_hold", data, 0);
    check("midgap_level_after", level, 0);

    // ---------------- wrap: stream 1..20 ------------------------------------
    clear_strobes();
    v = 1;
    budget = 0;
    while (v <= 20 && budget < 300) begin
      in_valid = 1'b1;
      in_data  = v[8:0];
      acc      = in_ready;
      tick(1);
      if (acc) v++;
      budget++;
    end
    in_valid = 1'b0;
    check("wrap_sent_all", v, 21);
    budget = 0;
    while (strb_val.size() < 20 && budget < 300) begin
      tick(1);
      budget++;
    end
    tick(1);
    check("wrap_count", strb_val.size(), 20);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("wrap_v%0d", i), q_at(i), i + 1);
    end
    min_sp = 1000;
    for (int i = 1; i < strb_cyc.size(); i++) begin
      if (strb_cyc[i] - strb_cyc[i-1] < min_sp) min_sp = strb_cyc[i] - strb_cyc[i-1];
    end
    check("wrap_min_spacing", min_sp, 3);

`ifdef FIR_FEEDER_STATS_EN
    // ---------------- strobe counter ----------------------------------------
    rst = 1'b1;
    tick(1);
    check("stats_rst0", issued_cnt, 0);
    rst = 1'b0;
    clear_strobes();
    v = 31;
    budget = 0;
    while (v <= 35 && budget < 100) begin
      in_valid = 1'b1;
      in_data  = v[8:0];
      acc      = in_ready;
      tick(1);
      if (acc) v++;
      budget++;
    end
    in_valid = 1'b0;
    tick(20);
    check("stats_strobes", strb_val.size(), 5);
    check("stats_cnt5", issued_cnt, 5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("stats_cnt_rst", issued_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_fir_sample_feeder
`default_nettype wire
